// File: rtl/aim_pkg.sv
// Shared constants, ternary weight encodings and FSM states for the AIM pipeline.
// Latency: n/a (package).
// Backpressure: n/a (package).
package aim_pkg;

  localparam int N     = 128;         // pairs per frame
  localparam int ACT_W = 9;           // signed activation width
  localparam int CNT_W = 8;           // count width, 2**CNT_W > N
  localparam int IDX_W = $clog2(N);   // pair index / store rank width

  // Ternary weight encodings
  localparam logic [1:0] WGT_ZERO = 2'b00;
  localparam logic [1:0] WGT_POS  = 2'b01;
  localparam logic [1:0] WGT_NEG  = 2'b11;
  localparam logic [1:0] WGT_ILL  = 2'b10;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // True for a legal non-zero weight; the illegal code reads as zero.
  function automatic logic wgt_is_nz(input logic [1:0] w);
    logic nz;
    case (w)
      WGT_POS, WGT_NEG:  nz = 1'b1;
      WGT_ZERO, WGT_ILL: nz = 1'b0;
      default:           nz = 1'b0;
    endcase
    return nz;
  endfunction

endpackage

// File: rtl/aim_sparse_encoder_if.sv
// Pair stream in, held sparse frame out, plus the packed-store read port.
// Latency: n/a (bundle of wires).
// Backpressure: in_ready/out_ready carry flow control for the two streams.
interface aim_sparse_encoder_if;
  import aim_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACT_W-1:0] in_act;
  logic [1:0]              in_wgt;
  logic                    in_last;

  logic                    out_valid;
  logic                    out_ready;
  logic [N-1:0]            act_index;
  logic [N-1:0]            wgt_index;
  logic [N-1:0]            and_index;
  logic [N-1:0]            wgt_neg;
  logic [CNT_W-1:0]        nnz_act;
  logic [CNT_W-1:0]        nnz_and;
  logic [IDX_W-1:0]        rd_addr;
  logic signed [ACT_W-1:0] rd_data;
  logic                    err;

  // Encoder side
  modport slave (
    input  in_valid, in_act, in_wgt, in_last, out_ready, rd_addr,
    output in_ready, out_valid, act_index, wgt_index, and_index, wgt_neg,
           nnz_act, nnz_and, rd_data, err
  );

  // Upstream feeder / downstream consumer side
  modport master (
    output in_valid, in_act, in_wgt, in_last, out_ready, rd_addr,
    input  in_ready, out_valid, act_index, wgt_index, and_index, wgt_neg,
           nnz_act, nnz_and, rd_data, err
  );

endinterface

// File: rtl/aim_act_store.sv
// N x ACT_W register file: one synchronous write port, one combinational read port.
// Latency: write visible the cycle after wr_en; read is same-cycle.
// Backpressure: none; writes are unconditional when wr_en is high.
module aim_act_store #(
  parameter int N     = 128,
  parameter int ACT_W = 9,
  parameter int AW    = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [ACT_W-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic signed [ACT_W-1:0] rd_data
);

  logic signed [ACT_W-1:0] mem [N];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/aim_sparse_encoder.sv
// Builds activation/weight/match/sign bitmaps and a packed non-zero activation store per frame.
// Latency: one pair per cycle; out_valid rises on the edge accepting the final pair.
// Backpressure: in_ready low while a finished frame is held; one bubble cycle after out_ready.
module aim_sparse_encoder
  import aim_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  aim_sparse_encoder_if.slave bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     act_index_q, wgt_index_q, wgt_neg_q;
  logic [CNT_W-1:0] nnz_act_q, nnz_and_q;
  logic             err_q;

  logic accept, frame_end, clear;
  logic act_nz, wgt_nz, wgt_neg_in, wgt_ill, at_last_slot, overrun;
  logic store_we;

  // Classify the incoming pair
  always_comb begin
    act_nz       = (bus.in_act != '0);
    wgt_nz       = wgt_is_nz(bus.in_wgt);
    wgt_neg_in   = (bus.in_wgt == WGT_NEG);
    wgt_ill      = (bus.in_wgt == WGT_ILL);
    at_last_slot = (idx_q == IDX_W'(N - 1));
    overrun      = at_last_slot & ~bus.in_last;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; a frame also closes when the last slot fills
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    frame_end     = 1'b0;
    clear         = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state_q)
      FILL: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        frame_end    = accept & (bus.in_last | at_last_slot);
        if (frame_end) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        clear         = bus.out_ready;
        if (clear) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Bitmaps, counts and pair pointer; cleared on handoff, updated on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      act_index_q <= '0;
      wgt_index_q <= '0;
      wgt_neg_q   <= '0;
      nnz_act_q   <= '0;
      nnz_and_q   <= '0;
    end else if (clear) begin
      idx_q       <= '0;
      act_index_q <= '0;
      wgt_index_q <= '0;
      wgt_neg_q   <= '0;
      nnz_act_q   <= '0;
      nnz_and_q   <= '0;
    end else if (accept) begin
      act_index_q[idx_q] <= act_nz;
      wgt_index_q[idx_q] <= wgt_nz;
      wgt_neg_q[idx_q]   <= wgt_neg_in;
      nnz_act_q          <= nnz_act_q + {{(CNT_W-1){1'b0}}, act_nz};
      nnz_and_q          <= nnz_and_q + {{(CNT_W-1){1'b0}}, act_nz & wgt_nz};
      idx_q              <= idx_q + 1'b1;
    end
  end

  // Sticky error: illegal weight code or a full frame without in_last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept & (wgt_ill | overrun)) begin
      err_q <= 1'b1;
    end
  end

  // Non-zero activations pack into the store at the current rank
  assign store_we = accept & act_nz;

  aim_act_store #(
    .N     (N),
    .ACT_W (ACT_W),
    .AW    (IDX_W)
  ) u_act_store (
    .clk     (clk),
    .wr_en   (store_we),
    .wr_addr (nnz_act_q[IDX_W-1:0]),
    .wr_data (bus.in_act),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.act_index = act_index_q;
  assign bus.wgt_index = wgt_index_q;
  assign bus.and_index = act_index_q & wgt_index_q;
  assign bus.wgt_neg   = wgt_neg_q;
  assign bus.nnz_act   = nnz_act_q;
  assign bus.nnz_and   = nnz_and_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_aim_sparse_encoder.sv
// Self-checking bench for aim_sparse_encoder against a frame-level reference model.
// Latency: n/a.
// Backpressure: exercises held-frame stall and handoff bubble.
module tb_aim_sparse_encoder;
  import aim_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aim_sparse_encoder_if bus ();

  aim_sparse_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Frame stimulus
  logic [ACT_W-1:0] f_act [256];
  logic [1:0]       f_wgt [256];

  // Reference expectations
  logic [N-1:0]     exp_act, exp_wgt, exp_neg;
  int               exp_nnz_act, exp_nnz_and;
  logic [ACT_W-1:0] exp_store [$];
  logic             exp_err = 1'b0;

  task automatic check_eq(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-frame reference: what the sparse view of pairs 0..n-1 must look like
  task automatic model_frame(input int n, input bit last);
    exp_act = '0;
    exp_wgt = '0;
    exp_neg = '0;
    exp_store.delete();
    for (int i = 0; i < n; i++) begin
      bit a, w;
      a = (f_act[i] != '0);
      w = (f_wgt[i] == 2'b01) || (f_wgt[i] == 2'b11);
      exp_act[i] = a;
      exp_wgt[i] = w;
      exp_neg[i] = (f_wgt[i] == 2'b11);
      if (a) exp_store.push_back(f_act[i]);
      if (f_wgt[i] == 2'b10) exp_err = 1'b1;
    end
    if (n == N && !last) exp_err = 1'b1;
    exp_nnz_act = exp_store.size();
    exp_nnz_and = $countones(exp_act & exp_wgt);
  endtask

  task automatic send_frame(input int n, input bit last);
    for (int i = 0; i < n; i++) begin
      int w;
      bus.in_valid = 1'b1;
      bus.in_act   = f_act[i];
      bus.in_wgt   = f_wgt[i];
      bus.in_last  = last && (i == n - 1);
      w = 0;
      while (!bus.in_ready && w < 40) begin
        @(posedge clk); #1;
        w++;
      end
      if (!bus.in_ready) check_eq("accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic check_frame(input string tag, input bit hold);
    check_eq({tag, "_out_valid"}, bus.out_valid, hold);
    check_eq({tag, "_in_ready"},  bus.in_ready, !hold);
    check_eq({tag, "_act_index"}, bus.act_index, exp_act);
    check_eq({tag, "_wgt_index"}, bus.wgt_index, exp_wgt);
    check_eq({tag, "_and_index"}, bus.and_index, exp_act & exp_wgt);
    check_eq({tag, "_wgt_neg"},   bus.wgt_neg, exp_neg);
    check_eq({tag, "_nnz_act"},   bus.nnz_act, exp_nnz_act);
    check_eq({tag, "_nnz_and"},   bus.nnz_and, exp_nnz_and);
    check_eq({tag, "_err"},       bus.err, exp_err);
    for (int r = 0; r < exp_store.size(); r++) begin
      bus.rd_addr = IDX_W'(r);
      #1;
      check_eq({tag, "_store"}, $unsigned(bus.rd_data), exp_store[r]);
    end
    @(posedge clk); #1;
  endtask

  task automatic handoff(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq({tag, "_ho_out_valid"}, bus.out_valid, 0);
    check_eq({tag, "_ho_in_ready"},  bus.in_ready, 1);
    check_eq({tag, "_ho_nnz_act"},   bus.nnz_act, 0);
    check_eq({tag, "_ho_nnz_and"},   bus.nnz_and, 0);
    check_eq({tag, "_ho_act_index"}, bus.act_index, 0);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    exp_err = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic rand_frame(input int n);
    for (int i = 0; i < n; i++) begin
      f_act[i] = ($urandom_range(0, 9) < 3) ? '0 : ACT_W'($urandom);
      case ($urandom_range(0, 2))
        0:       f_wgt[i] = 2'b00;
        1:       f_wgt[i] = 2'b01;
        default: f_wgt[i] = 2'b11;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_act    = '0;
    bus.in_wgt    = 2'b00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    bus.rd_addr   = '0;

    // Reset state
    #1;
    check_eq("rst_in_ready_async", bus.in_ready, 1);
    apply_reset();
    check_eq("rst_in_ready",  bus.in_ready, 1);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_err",       bus.err, 0);
    check_eq("rst_act_index", bus.act_index, 0);
    check_eq("rst_wgt_index", bus.wgt_index, 0);
    check_eq("rst_wgt_neg",   bus.wgt_neg, 0);
    check_eq("rst_nnz_act",   bus.nnz_act, 0);
    check_eq("rst_nnz_and",   bus.nnz_and, 0);

    // Full dense frame
    for (int i = 0; i < N; i++) begin
      f_act[i] = ACT_W'(i + 1);
      f_wgt[i] = (i % 2 == 0) ? 2'b01 : 2'b11;
    end
    send_frame(N, 1'b1);
    model_frame(N, 1'b1);
    check_eq("dense_act_ones", bus.act_index, {N{1'b1}});
    check_eq("dense_neg_pat",  bus.wgt_neg, {(N/2){2'b10}});
    check_eq("dense_nnz_and",  bus.nnz_and, 128);
    bus.rd_addr = 7'd5;
    #1;
    check_eq("dense_rd5", $unsigned(bus.rd_data), 6);
    check_frame("dense", 1'b1);
    handoff("dense");

    // Sparse mix, then a held-frame stall with a pending pair
    f_act[0] = 9'd0;   f_wgt[0] = 2'b00;
    f_act[1] = 9'd7;   f_wgt[1] = 2'b00;
    f_act[2] = 9'd0;   f_wgt[2] = 2'b01;
    f_act[3] = 9'h1FD; f_wgt[3] = 2'b11;
    send_frame(4, 1'b1);
    model_frame(4, 1'b1);
    check_eq("mix_act",     bus.act_index, 4'b1010);
    check_eq("mix_wgt",     bus.wgt_index, 4'b1100);
    check_eq("mix_and",     bus.and_index, 4'b1000);
    check_eq("mix_neg",     bus.wgt_neg, 4'b1000);
    check_eq("mix_nnz_act", bus.nnz_act, 2);
    check_eq("mix_nnz_and", bus.nnz_and, 1);
    bus.rd_addr = 7'd1;
    #1;
    check_eq("mix_store1", $unsigned(bus.rd_data), 9'h1FD);
    check_frame("mix", 1'b1);

    bus.in_valid = 1'b1;
    bus.in_act   = 9'd33;
    bus.in_wgt   = 2'b01;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check_eq("bp_out_valid", bus.out_valid, 1);
      check_eq("bp_in_ready",  bus.in_ready, 0);
      check_eq("bp_act_index", bus.act_index, exp_act);
      check_eq("bp_nnz_act",   bus.nnz_act, exp_nnz_act);
    end
    handoff("bp");
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    // Randomized frames of random length
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, N);
      rand_frame(n);
      send_frame(n, 1'b1);
      model_frame(n, 1'b1);
      check_frame("rand", 1'b1);
      handoff("rand");
    end

    // Overrun: 128 pairs without in_last close the frame and flag err
    rand_frame(N + 2);
    send_frame(N, 1'b0);
    model_frame(N, 1'b0);
    check_frame("ovr", 1'b1);
    handoff("ovr");
    f_act[0] = f_act[N];
    f_wgt[0] = f_wgt[N];
    f_act[1] = f_act[N + 1];
    f_wgt[1] = f_wgt[N + 1];
    send_frame(2, 1'b0);
    model_frame(2, 1'b0);
    check_frame("ovr_next", 1'b0);
    apply_reset();

    // Illegal weight code reads as zero and flags err
    f_act[0] = 9'd5;
    f_wgt[0] = 2'b10;
    send_frame(1, 1'b1);
    model_frame(1, 1'b1);
    check_eq("ill_wgt0", bus.wgt_index[0], 0);
    check_eq("ill_and",  bus.and_index, 0);
    check_eq("ill_act0", bus.act_index[0], 1);
    check_eq("ill_err",  bus.err, 1);
    check_frame("ill", 1'b1);
    handoff("ill");
    apply_reset();

    // Reset partway through a frame
    rand_frame(60);
    send_frame(60, 1'b0);
    rst_n   = 1'b0;
    exp_err = 1'b0;
    #1;
    check_eq("mrst_out_valid", bus.out_valid, 0);
    check_eq("mrst_in_ready",  bus.in_ready, 1);
    check_eq("mrst_nnz_act",   bus.nnz_act, 0);
    check_eq("mrst_nnz_and",   bus.nnz_and, 0);
    check_eq("mrst_act_index", bus.act_index, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rand_frame(4);
    send_frame(4, 1'b1);
    model_frame(4, 1'b1);
    check_frame("post_rst", 1'b1);
    handoff("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
